video_timing_gen: RTL and testbench

- Generates the raster timing that feeds the TMDS encoder stage: data-enable (VDE), control data ({vsync, hsync} as CD), and pixel-request coordinates.
- Pixel coordinates lead VDE/CD by LEAD cycles, so a pixel source (e.g. tetris board renderer/ROM) with LEAD-cycle latency delivers VD aligned with VDE.
- Start/stop is frame-clean: an enable input starts scanning at the next frame origin and stops only at a frame boundary.

---
 rtl/video_pkg.sv | 34 +++
 rtl/video_timing_gen_if.sv | 27 ++
 rtl/video_delay_line.sv | 35 +++
 rtl/video_timing_gen.sv | 134 +++++++++++++
 tb/tb_video_timing_gen.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/video_pkg.sv
// Shared 640x480@60 raster constants, FSM state encoding and CD control tokens
// used by the timing generator and the TMDS encoder stage.
package video_pkg;

  localparam int H_ACTIVE_640 = 640;
  localparam int H_FP_640     = 16;
  localparam int H_SYNC_640   = 96;
  localparam int H_BP_640     = 48;
  localparam int V_ACTIVE_480 = 480;
  localparam int V_FP_480     = 10;
  localparam int V_SYNC_480   = 2;
  localparam int V_BP_480     = 33;

  // Raw {vsync, hsync} tokens as the encoder sees them on the blue channel.
  typedef logic [1:0] cd_t;
  localparam cd_t CD_00 = 2'b00;
  localparam cd_t CD_01 = 2'b01;
  localparam cd_t CD_10 = 2'b10;
  localparam cd_t CD_11 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } vtg_state_t;

  function automatic int vtg_total(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int H_TOTAL_640 = vtg_total(H_ACTIVE_640, H_FP_640, H_SYNC_640, H_BP_640);
  localparam int V_TOTAL_480 = vtg_total(V_ACTIVE_480, V_FP_480, V_SYNC_480, V_BP_480);

endpackage

// File: rtl/video_timing_gen_if.sv
// Pixel-request and encoder-facing timing bundle; master is the generator,
// slave is the pixel source / encoder side that also owns the run request.
interface video_timing_gen_if
  import video_pkg::*;
#(
  parameter int CW = 11
);
  logic          en;
  logic          req_valid;
  logic [CW-1:0] req_x;
  logic [CW-1:0] req_y;
  logic          line_start;
  logic          frame_start;
  logic          VDE;
  cd_t           CD;
  logic          running;

  modport master (
    input  en,
    output req_valid, req_x, req_y, line_start, frame_start, VDE, CD, running
  );

  modport slave (
    output en,
    input  req_valid, req_x, req_y, line_start, frame_start, VDE, CD, running
  );
endinterface

// File: rtl/video_delay_line.sv
// Fixed-depth register shift pipeline with a parameterised reset value;
// DEPTH=0 degenerates to a wire.
module video_delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             pixclk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = pixclk ^ rst_n;
      assign q = d;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
        end else begin
          stage[0] <= d;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign q = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: frame-clean start/stop FSM, h/v counters, registered
// pixel request stage and LEAD-cycle delayed VDE/CD toward the TMDS encoder.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_640,
  parameter int H_FP     = H_FP_640,
  parameter int H_SYNC   = H_SYNC_640,
  parameter int H_BP     = H_BP_640,
  parameter int V_ACTIVE = V_ACTIVE_480,
  parameter int V_FP     = V_FP_480,
  parameter int V_SYNC   = V_SYNC_480,
  parameter int V_BP     = V_BP_480,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int LEAD     = 1,
  parameter int CW       = 11
) (
  input  logic               pixclk,
  input  logic               rst_n,
  video_timing_gen_if.master vif
);

  localparam int H_TOTAL = vtg_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = vtg_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam cd_t           CD_IDLE  = {~VS_POL, ~HS_POL};

  vtg_state_t    state, state_next;
  logic [CW-1:0] h, v;
  logic          scanning, last_pixel;
  logic          hs_on, vs_on;

  logic          req_valid_s0, line_start_s0, frame_start_s0;
  logic [CW-1:0] req_x_s0, req_y_s0;
  cd_t           sync_s0;

  assign scanning   = (state != ST_IDLE);
  assign last_pixel = (h == H_LAST) && (v == V_LAST);

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Stopping only retires at the last pixel, so frames are never cut short.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:     if (vif.en) state_next = ST_RUN;
      ST_RUN:      if (!vif.en) state_next = ST_STOPPING;
      ST_STOPPING: begin
        if (vif.en)          state_next = ST_RUN;
        else if (last_pixel) state_next = ST_IDLE;
      end
      default:     state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      h <= '0;
      v <= '0;
    end else if (!scanning) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  assign hs_on = scanning && (h >= HS_START) && (h < HS_END);
  assign vs_on = scanning && (v >= VS_START) && (v < VS_END);

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      req_valid_s0   <= 1'b0;
      req_x_s0       <= '0;
      req_y_s0       <= '0;
      line_start_s0  <= 1'b0;
      frame_start_s0 <= 1'b0;
      sync_s0        <= CD_IDLE;
    end else begin
      req_valid_s0   <= scanning && (h < H_ACT) && (v < V_ACT);
      req_x_s0       <= h;
      req_y_s0       <= v;
      line_start_s0  <= scanning && (h == '0);
      frame_start_s0 <= scanning && (h == '0) && (v == '0);
      sync_s0        <= {vs_on ? VS_POL : ~VS_POL, hs_on ? HS_POL : ~HS_POL};
    end
  end

  // VDE/CD trail the request by LEAD cycles to cover the pixel source latency.
  video_delay_line #(
    .WIDTH    (1),
    .DEPTH    (LEAD),
    .RESET_VAL(1'b0)
  ) u_vde_delay (
    .pixclk(pixclk),
    .rst_n (rst_n),
    .d     (req_valid_s0),
    .q     (vif.VDE)
  );

  video_delay_line #(
    .WIDTH    (2),
    .DEPTH    (LEAD),
    .RESET_VAL(CD_IDLE)
  ) u_cd_delay (
    .pixclk(pixclk),
    .rst_n (rst_n),
    .d     (sync_s0),
    .q     (vif.CD)
  );

  assign vif.req_valid   = req_valid_s0;
  assign vif.req_x       = req_x_s0;
  assign vif.req_y       = req_y_s0;
  assign vif.line_start  = line_start_s0;
  assign vif.frame_start = frame_start_s0;
  assign vif.running     = scanning;

endmodule

// File: tb/tb_video_timing_gen.sv
// Checks three generator instances (LEAD=1 medium raster, LEAD=0 and LEAD=3 small
// rasters) against a raster-position model driven by a random run request.
module tb_video_timing_gen;
  import video_pkg::*;

  typedef struct packed {
    logic        valid;
    logic [10:0] x;
    logic [10:0] y;
    logic        ls;
    logic        fs;
    logic [1:0]  cd;
  } rec_t;

  logic pixclk = 1'b0;
  logic rst_n  = 1'b0;
  logic en     = 1'b0;

  always #5 pixclk = ~pixclk;

  video_timing_gen_if #(.CW(11)) vif_m ();
  video_timing_gen_if #(.CW(11)) vif_a ();
  video_timing_gen_if #(.CW(11)) vif_b ();

  assign vif_m.en = en;
  assign vif_a.en = en;
  assign vif_b.en = en;

  video_timing_gen #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(3), .V_BP(2),
    .HS_POL(1'b0), .VS_POL(1'b0), .LEAD(1), .CW(11)
  ) u_dut_m (.pixclk(pixclk), .rst_n(rst_n), .vif(vif_m));

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .LEAD(0), .CW(11)
  ) u_dut_a (.pixclk(pixclk), .rst_n(rst_n), .vif(vif_a));

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .LEAD(3), .CW(11)
  ) u_dut_b (.pixclk(pixclk), .rst_n(rst_n), .vif(vif_b));

  int cfg_ha[3]   = '{16, 8, 8};
  int cfg_hfp[3]  = '{4, 2, 2};
  int cfg_hs[3]   = '{6, 2, 2};
  int cfg_hbp[3]  = '{4, 2, 2};
  int cfg_va[3]   = '{10, 4, 4};
  int cfg_vfp[3]  = '{2, 1, 1};
  int cfg_vs[3]   = '{3, 1, 1};
  int cfg_vbp[3]  = '{2, 1, 1};
  bit cfg_hpol[3] = '{1'b0, 1'b1, 1'b0};
  bit cfg_vpol[3] = '{1'b0, 1'b1, 1'b0};
  int cfg_lead[3] = '{1, 0, 3};

  // Model: a linear pixel position within the frame plus whether scanning.
  bit   m_act[3];
  int   m_pos[3];
  bit   m_enprev[3];
  rec_t m_hist[3][8];

  int tests_run    = 0;
  int tests_failed = 0;

  function automatic rec_t viewRec(int d, bit act, int p);
    rec_t r;
    int   ht, h, v, hs0, vs0;
    bit   hs_on, vs_on;
    ht    = cfg_ha[d] + cfg_hfp[d] + cfg_hs[d] + cfg_hbp[d];
    h     = act ? p % ht : 0;
    v     = act ? p / ht : 0;
    hs0   = cfg_ha[d] + cfg_hfp[d];
    vs0   = cfg_va[d] + cfg_vfp[d];
    hs_on = act && h >= hs0 && h < hs0 + cfg_hs[d];
    vs_on = act && v >= vs0 && v < vs0 + cfg_vs[d];
    r.valid = act && h < cfg_ha[d] && v < cfg_va[d];
    r.x     = 11'(h);
    r.y     = 11'(v);
    r.ls    = act && h == 0;
    r.fs    = act && h == 0 && v == 0;
    r.cd    = {vs_on ? cfg_vpol[d] : !cfg_vpol[d], hs_on ? cfg_hpol[d] : !cfg_hpol[d]};
    return r;
  endfunction

  task automatic modelReset();
    for (int d = 0; d < 3; d++) begin
      m_act[d]    = 1'b0;
      m_pos[d]    = 0;
      m_enprev[d] = 1'b0;
      for (int i = 0; i < 8; i++) m_hist[d][i] = viewRec(d, 1'b0, 0);
    end
  endtask

  task automatic modelStep();
    int total;
    for (int d = 0; d < 3; d++) begin
      total = (cfg_ha[d] + cfg_hfp[d] + cfg_hs[d] + cfg_hbp[d]) *
              (cfg_va[d] + cfg_vfp[d] + cfg_vs[d] + cfg_vbp[d]);
      for (int i = 7; i > 0; i--) m_hist[d][i] = m_hist[d][i-1];
      m_hist[d][0] = viewRec(d, m_act[d], m_pos[d]);
      if (!m_act[d]) begin
        if (en) begin
          m_act[d] = 1'b1;
          m_pos[d] = 0;
        end
      end else if (!en && !m_enprev[d] && m_pos[d] == total - 1) begin
        m_act[d] = 1'b0;
        m_pos[d] = 0;
      end else begin
        m_pos[d] = (m_pos[d] + 1) % total;
      end
      m_enprev[d] = en;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkDut(input int d, input logic valid, input logic [10:0] x,
                          input logic [10:0] y, input logic ls, input logic fs,
                          input logic vde, input logic [1:0] cd, input logic run);
    rec_t e, l;
    e = m_hist[d][0];
    l = m_hist[d][cfg_lead[d]];
    checkOutput($sformatf("d%0d.req", d), {7'd0, valid, x, y, ls, fs},
                {7'd0, e.valid, e.x, e.y, e.ls, e.fs});
    checkOutput($sformatf("d%0d.vde", d), {31'd0, vde}, {31'd0, l.valid});
    checkOutput($sformatf("d%0d.cd", d), {30'd0, cd}, {30'd0, l.cd});
    checkOutput($sformatf("d%0d.running", d), {31'd0, run}, {31'd0, m_act[d]});
  endtask

  task automatic checkAll();
    checkDut(0, vif_m.req_valid, vif_m.req_x, vif_m.req_y, vif_m.line_start,
             vif_m.frame_start, vif_m.VDE, vif_m.CD, vif_m.running);
    checkDut(1, vif_a.req_valid, vif_a.req_x, vif_a.req_y, vif_a.line_start,
             vif_a.frame_start, vif_a.VDE, vif_a.CD, vif_a.running);
    checkDut(2, vif_b.req_valid, vif_b.req_x, vif_b.req_y, vif_b.line_start,
             vif_b.frame_start, vif_b.VDE, vif_b.CD, vif_b.running);
  endtask

  task automatic stepCycle();
    @(posedge pixclk);
    if (rst_n) modelStep();
    @(negedge pixclk);
    checkAll();
  endtask

  task automatic applyStimulus(input logic en_val, input int cycles);
    en = en_val;
    repeat (cycles) stepCycle();
  endtask

  initial begin
    int  lat, period;
    bit  found;

    modelReset();
    repeat (3) @(negedge pixclk);
    checkAll();
    rst_n = 1'b1;
    applyStimulus(1'b0, 5);

    en    = 1'b1;
    lat   = 0;
    found = 1'b0;
    while (!found && lat < 10) begin
      stepCycle();
      lat++;
      if (vif_m.frame_start) found = 1'b1;
    end
    checkOutput("fs_latency", 32'(lat), 32'd2);

    period = 0;
    found  = 1'b0;
    while (!found && period < 1200) begin
      stepCycle();
      period++;
      if (vif_m.frame_start) found = 1'b1;
    end
    checkOutput("fs_period", 32'(period), 32'd510);

    applyStimulus(1'b1, 300);
    applyStimulus(1'b0, 600);
    checkOutput("stopped_cd", {30'd0, vif_m.CD}, {30'd0, CD_11});

    applyStimulus(1'b1, 200);
    applyStimulus(1'b0, 100);
    applyStimulus(1'b1, 300);

    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 99) < 2) en = ~en;
      stepCycle();
    end

    applyStimulus(1'b1, 777);
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkAll();
    repeat (2) stepCycle();
    rst_n = 1'b1;
    applyStimulus(1'b1, 600);
    applyStimulus(1'b0, 700);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
